clk_rst_seq: RTL
================

// Module: clk_rst_seq
// PURPOSE
//  Clock-enable and reset sequencer running in the 33 MHz system domain
//  (clk_sys = buffered board clock). Generalises the fixed single-output
//  clock block. It qualifies the DCM lock and releases NUM_CH per-domain
//  resets in staggered order, then generates NUM_CH programmable clock
//  enables that replace derived clocks (e.g. the former divide-by-10).
// PARAMETERS
//  NUM_CH       4     number of sequenced domains / clock-enable channels
//  DIV_W        8     divider width per channel
//  DIV_DEFAULT  9     divider value for all channels after rst_n (ce period = DIV+1)
//  LOCK_STABLE  1024  consecutive locked cycles required before release (>=2)
//  RST_STAGGER  16    cycles between successive channel reset releases (>=1)
// PORTS
//  clk         in   1            system clock (clk_sys)
//  rst_n       in   1            asynchronous, active-low reset
//  pll_locked  in   1            DCM LOCKED, asynchronous to clk
//  soft_rst    in   1            sync pulse: re-run release sequence
//  div_cfg     in   NUM_CH*DIV_W divider values, ch i at [i*DIV_W +: DIV_W]
//  div_load    in   1            sync pulse: latch div_cfg
//  rst_out_n   out  NUM_CH       per-domain active-low resets
//  ce_out      out  NUM_CH       per-channel one-cycle clock enables
//  sys_ready   out  1            all channels out of reset
//  lock_lost   out  1            sticky: lock dropped after first release
// BEHAVIOUR
//  - Reset (rst_n=0): rst_out_n=0, ce_out=0, sys_ready=0, lock_lost=0,
//    divisors=DIV_DEFAULT, FSM=S_WAIT_LOCK. All outputs registered.
//  - pll_locked passes a 2-flop synchroniser -> lk (2-cycle latency).
//  - FSM: S_WAIT_LOCK: lk=1 -> S_STABLE, cnt=0.
//    S_STABLE: cnt++ each cycle lk=1; lk=0 -> S_WAIT_LOCK; cnt==LOCK_STABLE-1
//    -> S_RELEASE, cnt=0. S_RELEASE: rst_out_n[i] goes 1 on the cycle cnt
//    reaches i*RST_STAGGER (ch0 on first RELEASE cycle); after channel
//    NUM_CH-1 is released -> S_RUN, sys_ready=1 the same edge. S_RUN: hold.
//  - Lock loss: lk=0 in S_RELEASE or S_RUN -> all rst_out_n=0, ce_out=0,
//    sys_ready=0 on the next edge; lock_lost=1 (sticky until rst_n);
//    -> S_WAIT_LOCK. lk=0 in S_STABLE does not set lock_lost.
//  - soft_rst in S_RELEASE/S_RUN: all rst_out_n=0, sys_ready=0 next edge,
//    -> S_STABLE with cnt=0 (full lock qualification repeated). Ignored in
//    S_WAIT_LOCK/S_STABLE. Lock loss has priority over soft_rst in same cycle.
//  - Divider ch i: counter held 0 and ce_out[i]=0 while rst_out_n[i]=0.
//    Running: ce_out[i]=1 when counter==div[i], counter wraps to 0, else ++.
//    First pulse DIV+1 cycles after release. div[i]=0 -> ce_out[i] constant 1.
//  - div_load: all div[i] latch div_cfg next edge and all counters clear to
//    0 (phase realigned, no short or long pulse beyond the new period).
//    div_load in the same cycle as a channel release: new value applies.
//  - Counters: stage counter width clog2(max(LOCK_STABLE,
//    (NUM_CH-1)*RST_STAGGER+1)); no wrap beyond terminal values.
// STRUCTURE
//  - Package clk_rst_pkg: FSM state encoding (S_WAIT_LOCK, S_STABLE,
//    S_RELEASE, S_RUN), function clog2.
//  - Sub-module clk_en_div (one divider channel: div, load, en, ce),
//    generated NUM_CH times; FSM, synchroniser and stagger logic in top.
// TESTING
//  1 rst_n release, pll_locked=1 at t0 -> rst_out_n[0]=1 at t0+2+1024+1
//    (+/-1 sync), rst_out_n[3] 48 cycles later, sys_ready with it.
//  2 Lock glitch 1 cycle at cnt=500 in S_STABLE -> count restarts,
//    release delayed accordingly, lock_lost stays 0.
//  3 In S_RUN drop pll_locked -> all rst_out_n=0, ce_out=0 within 3 cycles,
//    lock_lost=1; relock -> full sequence repeats, lock_lost still 1.
//  4 div defaults: ce_out period 10 cycles, exactly 1 cycle high; load
//    div_cfg ch0=0, ch1=1, ch2=255 -> ch0 constant 1, ch1 every 2, ch2 every 256.
//  5 soft_rst in S_RUN coincident with lock drop -> lock_lost=1, S_WAIT_LOCK.
//  6 Assert rst_n low mid-S_RELEASE -> all outputs to reset values
//    asynchronously, before next clk edge.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared types and constant helpers for the clock-enable / reset sequencer.
package clk_rst_pkg;

  // Sequencer states: wait for lock, qualify lock, staggered release, steady run
  typedef enum logic [1:0] {
    StWaitLock,
    StStable,
    StRelease,
    StRun
  } seq_state_e;

  // Ceiling log2 for elaboration-time width calculation
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One programmable clock-enable channel: ce pulses for one cycle every div+1 cycles
// while enabled; div=0 gives a constant-high enable.
module clk_en_div #(
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DIV_W-1:0] div,
  input  logic             load,
  input  logic             en,
  output logic             ce
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             ce_q, ce_d;

  // Next divisor, phase counter and enable pulse
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    ce_d  = 1'b0;
    if (load) div_d = div;
    if (!en || load) begin
      // Held in reset, or realigning phase to a freshly loaded divisor
      cnt_d = '0;
    end else if (cnt_q == div_q) begin
      cnt_d = '0;
      ce_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Divider state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(DIV_DEFAULT);
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Clock-enable and reset sequencer: qualifies DCM lock, releases per-domain resets in
// staggered order and drives one programmable clock-enable divider per domain.
module clk_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DIV_W       = 8,
  parameter int unsigned DIV_DEFAULT = 9,
  parameter int unsigned LOCK_STABLE = 1024,
  parameter int unsigned RST_STAGGER = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pll_locked,
  input  logic                    soft_rst,
  input  logic [NUM_CH*DIV_W-1:0] div_cfg,
  input  logic                    div_load,
  output logic [NUM_CH-1:0]       rst_out_n,
  output logic [NUM_CH-1:0]       ce_out,
  output logic                    sys_ready,
  output logic                    lock_lost
);

  localparam int unsigned RelLast = (NUM_CH - 1) * RST_STAGGER;
  localparam int unsigned CntW    = clog2(max_u(LOCK_STABLE, RelLast + 1));

  localparam logic [CntW-1:0] StableLast = CntW'(LOCK_STABLE - 1);
  localparam logic [CntW-1:0] RelLastCnt = CntW'(RelLast);

  seq_state_e        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_CH-1:0] rst_q, rst_d;
  logic              rdy_q, rdy_d;
  logic              lost_q, lost_d;
  logic              sync1_q, lk_q;
  logic [NUM_CH-1:0] run;

  // Two-flop synchroniser for the asynchronous lock indication
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      sync1_q <= pll_locked;
      lk_q    <= sync1_q;
    end
  end

  // Counter never runs past its terminal value in either counting state
  assign cnt_inc = cnt_q + CntW'(1);

  // Next-state logic: lock qualification, staggered release, lock-loss and soft reset
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    rdy_d   = rdy_q;
    lost_d  = lost_q;
    case (state_q)
      StWaitLock: begin
        if (lk_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end
      end
      StStable: begin
        if (!lk_q) begin
          state_d = StWaitLock;
        end else if (cnt_q == StableLast) begin
          cnt_d    = '0;
          rst_d[0] = 1'b1;
          if (NUM_CH == 1) begin
            state_d = StRun;
            rdy_d   = 1'b1;
          end else begin
            state_d = StRelease;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StRelease, StRun: begin
        // Lock loss wins over a simultaneous soft reset
        if (!lk_q) begin
          state_d = StWaitLock;
          rst_d   = '0;
          rdy_d   = 1'b0;
          lost_d  = 1'b1;
        end else if (soft_rst) begin
          state_d = StStable;
          cnt_d   = '0;
          rst_d   = '0;
          rdy_d   = 1'b0;
        end else if (state_q == StRelease) begin
          cnt_d = cnt_inc;
          for (int unsigned i = 1; i < NUM_CH; i++) begin
            if (cnt_inc == CntW'(i * RST_STAGGER)) rst_d[i] = 1'b1;
          end
          if (cnt_inc == RelLastCnt) begin
            state_d = StRun;
            rdy_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = StWaitLock;
      end
    endcase
  end

  // Sequencer state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitLock;
      cnt_q   <= '0;
      rst_q   <= '0;
      rdy_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      rdy_q   <= rdy_d;
      lost_q  <= lost_d;
    end
  end

  // Divider runs only while its domain stays released across this edge, so its ce
  // clears on the same edge as the reset and its phase starts at zero on release.
  assign run = rst_q & rst_d;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_en_div #(
      .DIV_W      (DIV_W),
      .DIV_DEFAULT(DIV_DEFAULT)
    ) u_div (
      .clk  (clk),
      .rst_n(rst_n),
      .div  (div_cfg[g*DIV_W +: DIV_W]),
      .load (div_load),
      .en   (run[g]),
      .ce   (ce_out[g])
    );
  end

  assign rst_out_n = rst_q;
  assign sys_ready = rdy_q;
  assign lock_lost = lost_q;

endmodule
